adpll_lock_ctrl: RTL and testbench
==================================

// Module: adpll_lock_ctrl
// PURPOSE
//  Loop-gain scheduler and lock controller for the ADPLL.
//  - Consumes one signed phase-error sample per reference period from the phase detector.
//  - Sequences the loop through acquisition, tracking and locked states.
//  - Drives the loop-filter gain shifts and the integrator clear.
//  - Reports lock status, lock loss and reference loss to the system.
// PARAMETERS
//  ERR_W      8    phase-error width (signed two's complement)
//  CNT_W      8    width of the qualification counters and the watchdog counter
//  ACQ_TH     16   |err| <= ACQ_TH counts as an acquisition-good sample
//  LOCK_TH    2    |err| <= LOCK_TH counts as a lock-good sample
//  UNLOCK_TH  8    |err| >  UNLOCK_TH counts as a lock-bad sample
//  GEAR_CNT   4    consecutive acquisition-good samples needed for ACQ->TRACK
//  LOCK_CNT   16   consecutive lock-good samples needed for TRACK->LOCKED
//  UNLOCK_CNT 3    consecutive lock-bad samples needed for LOCKED->ACQ
//  REF_TO     255  clk cycles without pd_valid before reference loss (must be < 2^CNT_W)
//  KP_ACQ/KI_ACQ 2/4  gain shifts used in IDLE and ACQ
//  KP_TRK/KI_TRK 4/8  gain shifts used in TRACK and LOCKED
// PORTS
//  clk        in   1      system clock (500 MHz)
//  rst        in   1      asynchronous reset, active high
//  enable     in   1      loop enable; low forces IDLE
//  pd_valid   in   1      one-cycle strobe, pd_error is valid
//  pd_error   in   ERR_W  signed phase error, sampled only when pd_valid=1
//  kp_shift   out  4      proportional gain right-shift to the loop filter
//  ki_shift   out  4      integral gain right-shift to the loop filter
//  integ_clr  out  1      one-cycle pulse, clears the loop-filter integrator
//  state      out  2      0=IDLE 1=ACQ 2=TRACK 3=LOCKED
//  locked     out  1      high while state==LOCKED
//  lock_lost  out  1      one-cycle pulse on LOCKED->ACQ
//  ref_lost   out  1      sticky flag for watchdog expiry; cleared by the next pd_valid
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: state=IDLE, kp/ki=KP_ACQ/KI_ACQ, all 1-bit outputs 0, all counters 0.
//  - |err| is computed in ERR_W bits. The most-negative input saturates to 2^(ERR_W-1)-1.
//  - A decision is made on each pd_valid cycle. The outputs reflect it on the next edge (latency 1).
//  - IDLE -> ACQ on the cycle enable=1. integ_clr pulses with that transition.
//  - ACQ:
//    - A good sample increments the good counter; a bad sample clears it.
//    - When the count reaches GEAR_CNT: go to TRACK and clear the counter.
//  - TRACK:
//    - |err| > ACQ_TH on any sample -> ACQ. Counter cleared, no integ_clr.
//    - Otherwise a lock-good sample increments the counter and a non-lock-good sample clears it.
//    - When the count reaches LOCK_CNT: go to LOCKED.
//  - LOCKED:
//    - A lock-bad sample increments the bad counter; any other sample clears it.
//    - When the count reaches UNLOCK_CNT: go to ACQ and pulse lock_lost.
//  - kp_shift/ki_shift change in the same cycle as state: ACQ gains in IDLE/ACQ, TRK gains in TRACK/LOCKED.
//  - Watchdog:
//    - Active whenever state != IDLE. Counts clk cycles since the last pd_valid.
//    - When the count reaches REF_TO: set ref_lost, go to ACQ (pulse lock_lost if leaving LOCKED), clear counters.
//    - The watchdog then restarts from 0.
//    - pd_valid in the same cycle as expiry: pd_valid wins and the watchdog is reset.
//  - Counters saturate and never wrap.
//  - Priority, highest first: rst > enable=0 (-> IDLE next edge, counters cleared, gains=ACQ, ref_lost cleared) > watchdog > sample decision.
//  - Reset asserted mid-operation returns everything to the reset values immediately (asynchronous).
// TESTING
//  1. Reset, enable=1, pd_valid every 60 clk with err=+10:
//     state=1 and integ_clr pulses 1 cycle after enable; after the 4th sample, state=2 and kp/ki=4/8.
//  2. From TRACK, 16 samples of err=-1:
//     state=3 and locked=1 on the edge after the 16th sample.
//     A 15-sample run broken by err=5 does not lock.
//  3. From LOCKED, err=+9 for 3 samples:
//     lock_lost pulses exactly 1 cycle, state=1, kp/ki=2/4.
//     Pattern 9,9,0,9,9 stays locked.
//  4. From TRACK, one sample err=+17 -> state=1, integ_clr stays 0.
//     Also pd_error=8'h80 -> treated as |err|=127 (bad).
//  5. From LOCKED, stop pd_valid:
//     after 255 clk, ref_lost=1, state=1, lock_lost pulses.
//     Next pd_valid clears ref_lost.
//     pd_valid on the expiry cycle -> no ref_lost.
//  6. enable=0 mid-LOCKED -> state=0 and locked=0 next edge.
//     Assert rst during TRACK -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/adpll_lock_ctrl.sv
// adpll_lock_ctrl
//   Loop-gain scheduler and lock controller for the ADPLL. Takes one signed
//   phase-error sample per reference period and walks the loop through
//   IDLE -> ACQ -> TRACK -> LOCKED. It selects the loop-filter gain shifts,
//   pulses the integrator clear on loop start, and flags lock loss and
//   reference loss (watchdog on pd_valid).
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   enable      : loop enable, low forces IDLE
//   pd_valid    : one-cycle strobe qualifying pd_error
//   pd_error    : signed phase error
//   kp_shift    : proportional gain right-shift
//   ki_shift    : integral gain right-shift
//   integ_clr   : one-cycle integrator clear on IDLE->ACQ
//   state       : 0=IDLE 1=ACQ 2=TRACK 3=LOCKED
//   locked      : high while LOCKED
//   lock_lost   : one-cycle pulse on LOCKED->ACQ
//   ref_lost    : sticky watchdog-expiry flag, cleared by the next pd_valid
module adpll_lock_ctrl #(
    parameter int          ERR_W      = 8,
    parameter int          CNT_W      = 8,
    parameter int          ACQ_TH     = 16,
    parameter int          LOCK_TH    = 2,
    parameter int          UNLOCK_TH  = 8,
    parameter int          GEAR_CNT   = 4,
    parameter int          LOCK_CNT   = 16,
    parameter int          UNLOCK_CNT = 3,
    parameter int          REF_TO     = 255,
    parameter logic [3:0]  KP_ACQ     = 4'd2,
    parameter logic [3:0]  KI_ACQ     = 4'd4,
    parameter logic [3:0]  KP_TRK     = 4'd4,
    parameter logic [3:0]  KI_TRK     = 4'd8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    pd_valid,
    input  logic signed [ERR_W-1:0] pd_error,
    output logic [3:0]              kp_shift,
    output logic [3:0]              ki_shift,
    output logic                    integ_clr,
    output logic [1:0]              state,
    output logic                    locked,
    output logic                    lock_lost,
    output logic                    ref_lost
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_TRACK  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MIN  = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [ERR_W-1:0] ERR_MAX  = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0] ACQ_T    = ERR_W'(ACQ_TH);
    localparam logic [ERR_W-1:0] LOCK_T   = ERR_W'(LOCK_TH);
    localparam logic [ERR_W-1:0] UNLOCK_T = ERR_W'(UNLOCK_TH);
    localparam logic [CNT_W-1:0] GEAR_N   = CNT_W'(GEAR_CNT);
    localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_CNT);
    // Watchdog fires in the cycle whose count would reach REF_TO.
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(REF_TO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] wd_q, wd_d, wd_inc;
    logic             ref_d, clr_d, lost_d;
    logic [ERR_W-1:0] abs_err;
    logic             acq_good, lock_good, lock_bad, wd_expire;

    // |err| in ERR_W bits; the most-negative code has no positive twin,
    // so it saturates to the largest positive value.
    always_comb begin
        abs_err = $unsigned(pd_error);
        if (pd_error[ERR_W-1]) begin
            if ($unsigned(pd_error) == ERR_MIN) abs_err = ERR_MAX;
            else                                abs_err = $unsigned(-pd_error);
        end
    end

    assign acq_good  = (abs_err <= ACQ_T);
    assign lock_good = (abs_err <= LOCK_T);
    assign lock_bad  = (abs_err >  UNLOCK_T);

    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    assign wd_inc    = (wd_q  == '1) ? wd_q  : wd_q  + CNT_ONE;
    // A pd_valid arriving on the expiry cycle pre-empts the watchdog.
    assign wd_expire = (st_q != S_IDLE) && !pd_valid && (wd_q >= WD_LAST);

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        wd_d   = wd_q;
        ref_d  = ref_lost;
        clr_d  = 1'b0;
        lost_d = 1'b0;
        if (!enable) begin
            st_d  = S_IDLE;
            cnt_d = '0;
            wd_d  = '0;
            ref_d = 1'b0;
        end else if (st_q == S_IDLE) begin
            st_d  = S_ACQ;
            clr_d = 1'b1;
            cnt_d = '0;
            wd_d  = '0;
        end else if (wd_expire) begin
            st_d   = S_ACQ;
            cnt_d  = '0;
            wd_d   = '0;
            ref_d  = 1'b1;
            lost_d = (st_q == S_LOCKED);
        end else if (!pd_valid) begin
            wd_d = wd_inc;
        end else begin
            wd_d  = '0;
            ref_d = 1'b0;
            case (st_q)
                S_ACQ: begin
                    if (!acq_good) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= GEAR_N) begin
                        st_d  = S_TRACK;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_TRACK: begin
                    if (!acq_good) begin
                        // Fall back without clearing the integrator.
                        st_d  = S_ACQ;
                        cnt_d = '0;
                    end else if (!lock_good) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= LOCK_N) begin
                        st_d  = S_LOCKED;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_LOCKED: begin
                    if (!lock_bad) begin
                        cnt_d = '0;
                    end else if (cnt_inc >= UNLOCK_N) begin
                        st_d   = S_ACQ;
                        cnt_d  = '0;
                        lost_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= S_IDLE;
            cnt_q     <= '0;
            wd_q      <= '0;
            kp_shift  <= KP_ACQ;
            ki_shift  <= KI_ACQ;
            integ_clr <= 1'b0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            ref_lost  <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            // Gains follow the next state so they switch on the same edge.
            kp_shift  <= (st_d == S_TRACK || st_d == S_LOCKED) ? KP_TRK : KP_ACQ;
            ki_shift  <= (st_d == S_TRACK || st_d == S_LOCKED) ? KI_TRK : KI_ACQ;
            integ_clr <= clr_d;
            locked    <= (st_d == S_LOCKED);
            lock_lost <= lost_d;
            ref_lost  <= ref_d;
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
`timescale 1ns/100ps
module tb_adpll_lock_ctrl;

    localparam int REF_TO = 255;
    localparam logic [14:0] RST_VEC = {2'd0, 1'b0, 4'd2, 4'd4, 3'b000};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       pd_valid = 1'b0;
    logic [7:0] pd_error = 8'd0;
    logic [3:0] kp_shift, ki_shift;
    logic       integ_clr, locked, lock_lost, ref_lost;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    // Reference model: streak counts per state, watchdog as elapsed cycles.
    int m_st = 0, m_run = 0, m_last = 0, cyc = 0;
    bit m_ref = 0, m_clr = 0, m_lost = 0;

    adpll_lock_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .pd_valid(pd_valid),
        .pd_error(pd_error), .kp_shift(kp_shift), .ki_shift(ki_shift),
        .integ_clr(integ_clr), .state(state), .locked(locked),
        .lock_lost(lock_lost), .ref_lost(ref_lost)
    );

    always #1 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int absv(input logic [7:0] e);
        int v = $signed(e);
        if (v < 0) v = -v;
        if (v > 127) v = 127;
        return v;
    endfunction

    function automatic logic [14:0] exp_vec();
        logic [3:0] kp = (m_st >= 2) ? 4'd4 : 4'd2;
        logic [3:0] ki = (m_st >= 2) ? 4'd8 : 4'd4;
        return {m_st[1:0], (m_st == 3), kp, ki, m_clr, m_lost, m_ref};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {state, locked, kp_shift, ki_shift, integ_clr, lock_lost, ref_lost};
    endfunction

    task automatic model_reset();
        m_st = 0; m_run = 0; m_ref = 0; m_clr = 0; m_lost = 0; m_last = cyc;
    endtask

    task automatic model_step(input bit en, input bit pv, input logic [7:0] e);
        int a = absv(e);
        m_clr = 0; m_lost = 0;
        if (!en) begin
            m_st = 0; m_run = 0; m_ref = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_clr = 1; m_run = 0; m_last = cyc;
        end else if (!pv && (cyc - m_last) >= REF_TO) begin
            m_lost = (m_st == 3); m_st = 1; m_run = 0; m_ref = 1; m_last = cyc;
        end else if (pv) begin
            m_last = cyc; m_ref = 0;
            if (m_st == 1) begin
                m_run = (a <= 16) ? m_run + 1 : 0;
                if (m_run == 4) begin m_st = 2; m_run = 0; end
            end else if (m_st == 2) begin
                if (a > 16) begin m_st = 1; m_run = 0; end
                else begin
                    m_run = (a <= 2) ? m_run + 1 : 0;
                    if (m_run == 16) begin m_st = 3; m_run = 0; end
                end
            end else begin
                m_run = (a > 8) ? m_run + 1 : 0;
                if (m_run == 3) begin m_st = 1; m_run = 0; m_lost = 1; end
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic tick(input bit en, input bit pv, input logic [7:0] e);
        enable = en; pd_valid = pv; pd_error = e;
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else     model_step(en, pv, e);
        #0.5;
        chk("outs", 32'(obs_vec()), 32'(exp_vec()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 8'd0);
    endtask

    task automatic samp(input logic [7:0] e, input int gap);
        idle(gap);
        tick(1, 1, e);
    endtask

    task automatic restart();
        tick(0, 0, 8'd0);
        tick(1, 0, 8'd0);
    endtask

    initial begin
        // Reset values
        tick(0, 0, 8'd0);
        tick(0, 0, 8'd0);
        rst = 1'b0;
        chk("rst_vals", 32'(obs_vec()), 32'(RST_VEC));

        // 1: enable, samples of +10 every 60 clk
        tick(1, 0, 8'd0);
        chk("t1_acq_state", state, 1);
        chk("t1_integ_clr", integ_clr, 1);
        tick(1, 0, 8'd0);
        chk("t1_clr_pulse", integ_clr, 0);
        for (int i = 0; i < 3; i++) samp(8'd10, 59);
        chk("t1_state_3smp", state, 1);
        samp(8'd10, 59);
        chk("t1_track", state, 2);
        chk("t1_kp", kp_shift, 4);
        chk("t1_ki", ki_shift, 8);

        // 2: broken run does not lock, full run does
        for (int i = 0; i < 15; i++) samp(8'hFF, 3);
        samp(8'd5, 3);
        chk("t2_no_lock", state, 2);
        for (int i = 0; i < 15; i++) samp(8'hFF, 3);
        chk("t2_15smp", state, 2);
        samp(8'hFF, 3);
        chk("t2_locked_st", state, 3);
        chk("t2_locked", locked, 1);

        // 3: 9,9,0,9,9 holds lock, one more 9 drops it
        samp(8'd9, 2); samp(8'd9, 2); samp(8'd0, 2); samp(8'd9, 2); samp(8'd9, 2);
        chk("t3_hold", state, 3);
        samp(8'd9, 2);
        chk("t3_lost", lock_lost, 1);
        chk("t3_acq", state, 1);
        chk("t3_kp", kp_shift, 2);
        chk("t3_ki", ki_shift, 4);
        tick(1, 0, 8'd0);
        chk("t3_lost_pulse", lock_lost, 0);

        // 4: large error in TRACK falls back without integ_clr
        for (int i = 0; i < 4; i++) samp(8'd0, 2);
        chk("t4_track", state, 2);
        samp(8'd17, 2);
        chk("t4_fallback", state, 1);
        chk("t4_no_clr", integ_clr, 0);
        for (int i = 0; i < 4; i++) samp(8'd0, 2);
        samp(8'h80, 2);
        chk("t4_minneg", state, 1);

        // 5: reference loss from LOCKED
        for (int i = 0; i < 20; i++) samp(8'd0, 1);
        chk("t5_locked", state, 3);
        idle(REF_TO - 1);
        chk("t5_not_yet", ref_lost, 0);
        tick(1, 0, 8'd0);
        chk("t5_ref_lost", ref_lost, 1);
        chk("t5_acq", state, 1);
        chk("t5_lock_lost", lock_lost, 1);
        tick(1, 0, 8'd0);
        chk("t5_ref_sticky", ref_lost, 1);
        samp(8'd0, 0);
        chk("t5_ref_clear", ref_lost, 0);
        idle(REF_TO - 1);
        tick(1, 1, 8'd0);
        chk("t5_pv_wins", ref_lost, 0);
        tick(1, 0, 8'd0);
        chk("t5_pv_wins2", ref_lost, 0);

        // 6: disable from LOCKED, async reset in TRACK
        restart();
        for (int i = 0; i < 20; i++) samp(8'd0, 1);
        chk("t6_locked", state, 3);
        tick(0, 0, 8'd0);
        chk("t6_idle", state, 0);
        chk("t6_unlocked", locked, 0);
        tick(1, 0, 8'd0);
        for (int i = 0; i < 4; i++) samp(8'd0, 1);
        chk("t6_track", state, 2);
        #0.2 rst = 1'b1;
        #0.1;
        chk("t6_async_rst", 32'(obs_vec()), 32'(RST_VEC));
        model_reset();
        tick(1, 0, 8'd0);
        rst = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(0, 99);
            int gap;
            logic [7:0] e;
            if (r < 3) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                    tick(0, $urandom_range(0, 1), 8'($urandom));
            end
            if (r >= 95)      gap = REF_TO - 1 + $urandom_range(0, 2);
            else              gap = $urandom_range(0, 25);
            r = $urandom_range(0, 99);
            if (r < 50)       e = 8'($signed($urandom_range(0, 4)) - 2);
            else if (r < 75)  e = 8'($signed($urandom_range(0, 16)) - 8);
            else if (r < 90)  e = 8'($signed($urandom_range(0, 40)) - 20);
            else              e = 8'($urandom);
            samp(e, gap);
        end
        pd_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
